// File: rtl/bsg_circular_ptr_fifo_tracker.sv
// Ring-buffer pointer/occupancy tracker with variable-size enqueue and dequeue per cycle.
// Optional sticky request-error flag: define BSG_CIRCULAR_PTR_FIFO_TRACKER_ERR_EN.
module bsg_circular_ptr_fifo_tracker #(
    parameter  int slots_p      = 128,
    parameter  int max_add_p    = 10,
    localparam int ptr_width_lp = $clog2(slots_p),
    localparam int cnt_width_lp = $clog2(slots_p + 1),
    localparam int add_width_lp = $clog2(max_add_p + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    enq_v_i,
    input  logic [add_width_lp-1:0] enq_add_i,
    output logic                    enq_ready_o,
    input  logic                    deq_v_i,
    input  logic [add_width_lp-1:0] deq_add_i,
    output logic                    deq_ready_o,
    output logic [ptr_width_lp-1:0] wptr_o,
    output logic [ptr_width_lp-1:0] rptr_o,
    output logic [ptr_width_lp-1:0] wptr_n_o,
    output logic [ptr_width_lp-1:0] rptr_n_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic [cnt_width_lp-1:0] free_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    err_o
);

    localparam int sum_width_lp = ptr_width_lp + 1;
    localparam logic [cnt_width_lp-1:0] slots_cnt_lc = cnt_width_lp'(slots_p);
    localparam logic [sum_width_lp-1:0] slots_sum_lc = sum_width_lp'(slots_p);

    logic [ptr_width_lp-1:0] wptr_q, wptr_d;
    logic [ptr_width_lp-1:0] rptr_q, rptr_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic [cnt_width_lp-1:0] enq_add_ext, deq_add_ext;
    logic                    enq_fit, deq_fit, enq_acc, deq_acc;

    // An accepted advance never exceeds slots_p, so one conditional subtract suffices.
    function automatic logic [ptr_width_lp-1:0] wrap_add(
        input logic [ptr_width_lp-1:0] ptr,
        input logic [add_width_lp-1:0] add
    );
        logic [sum_width_lp-1:0] sum;
        sum = {1'b0, ptr} + sum_width_lp'(add);
        if (sum >= slots_sum_lc) begin
            sum = sum - slots_sum_lc;
        end
        return sum[ptr_width_lp-1:0];
    endfunction

    assign enq_add_ext = cnt_width_lp'(enq_add_i);
    assign deq_add_ext = cnt_width_lp'(deq_add_i);
    assign free_o      = slots_cnt_lc - count_q;
    assign enq_fit     = (enq_add_ext <= free_o);
    assign deq_fit     = (deq_add_ext <= count_q);

    assign enq_ready_o = reset_n_i & enq_fit;
    assign deq_ready_o = reset_n_i & deq_fit;
    assign enq_acc     = enq_v_i & enq_ready_o;
    assign deq_acc     = deq_v_i & deq_ready_o;

    always_comb begin
        wptr_d  = enq_acc ? wrap_add(wptr_q, enq_add_i) : wptr_q;
        rptr_d  = deq_acc ? wrap_add(rptr_q, deq_add_i) : rptr_q;
        count_d = count_q + (enq_acc ? enq_add_ext : '0) - (deq_acc ? deq_add_ext : '0);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign wptr_o   = wptr_q;
    assign rptr_o   = rptr_q;
    assign wptr_n_o = wptr_d;
    assign rptr_n_o = rptr_d;
    assign count_o  = count_q;
    assign full_o   = (count_q == slots_cnt_lc);
    assign empty_o  = (count_q == '0);

`ifdef BSG_CIRCULAR_PTR_FIFO_TRACKER_ERR_EN
    localparam logic [add_width_lp-1:0] max_add_lc = add_width_lp'(max_add_p);

    logic err_q, err_d;

    // Reports rejected or out-of-range requests; never influences acceptance.
    always_comb begin
        err_d = err_q
              | (enq_v_i & ~enq_fit)
              | (deq_v_i & ~deq_fit)
              | (enq_v_i & (enq_add_i > max_add_lc))
              | (deq_v_i & (deq_add_i > max_add_lc));
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_circular_ptr_fifo_tracker.sv
// Directed bench for bsg_circular_ptr_fifo_tracker: a 128-slot instance and a 100-slot instance.
module tb_bsg_circular_ptr_fifo_tracker;

`ifdef BSG_CIRCULAR_PTR_FIFO_TRACKER_ERR_EN
    localparam bit err_en_lp = 1'b1;
`else
    localparam bit err_en_lp = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic exp_err = 1'b0;

    // 128-slot instance
    logic       enq_v_a, deq_v_a, enq_ready_a, deq_ready_a, full_a, empty_a, err_a;
    logic [3:0] enq_add_a, deq_add_a;
    logic [6:0] wptr_a, rptr_a, wptr_n_a, rptr_n_a;
    logic [7:0] count_a, free_a;

    // 100-slot instance
    logic       enq_v_b, deq_v_b, enq_ready_b, deq_ready_b, full_b, empty_b, err_b;
    logic [3:0] enq_add_b, deq_add_b;
    logic [6:0] wptr_b, rptr_b, wptr_n_b, rptr_n_b;
    logic [6:0] count_b, free_b;

    bsg_circular_ptr_fifo_tracker #(.slots_p(128), .max_add_p(10)) dut_a (
        .clk(clk), .reset_n_i(reset_n),
        .enq_v_i(enq_v_a), .enq_add_i(enq_add_a), .enq_ready_o(enq_ready_a),
        .deq_v_i(deq_v_a), .deq_add_i(deq_add_a), .deq_ready_o(deq_ready_a),
        .wptr_o(wptr_a), .rptr_o(rptr_a), .wptr_n_o(wptr_n_a), .rptr_n_o(rptr_n_a),
        .count_o(count_a), .free_o(free_a), .full_o(full_a), .empty_o(empty_a), .err_o(err_a)
    );

    bsg_circular_ptr_fifo_tracker #(.slots_p(100), .max_add_p(10)) dut_b (
        .clk(clk), .reset_n_i(reset_n),
        .enq_v_i(enq_v_b), .enq_add_i(enq_add_b), .enq_ready_o(enq_ready_b),
        .deq_v_i(deq_v_b), .deq_add_i(deq_add_b), .deq_ready_o(deq_ready_b),
        .wptr_o(wptr_b), .rptr_o(rptr_b), .wptr_n_o(wptr_n_b), .rptr_n_o(rptr_n_b),
        .count_o(count_b), .free_o(free_b), .full_o(full_b), .empty_o(empty_b), .err_o(err_b)
    );

    task automatic drive_a(input logic ev, input logic [3:0] ea, input logic dv, input logic [3:0] da);
        enq_v_a = ev; enq_add_a = ea; deq_v_a = dv; deq_add_a = da;
        #1;
    endtask

    task automatic drive_b(input logic ev, input logic [3:0] ea, input logic dv, input logic [3:0] da);
        enq_v_b = ev; enq_add_b = ea; deq_v_b = dv; deq_add_b = da;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        $display("txn t=%0t A: w=%0d r=%0d cnt=%0d | B: w=%0d r=%0d cnt=%0d",
                 $time, wptr_a, rptr_a, count_a, wptr_b, rptr_b, count_b);
    endtask

    task automatic do_reset();
        drive_a(1'b0, 4'd0, 1'b0, 4'd0);
        drive_b(1'b0, 4'd0, 1'b0, 4'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        #1;
        exp_err = 1'b0;
    endtask

    task automatic test_reset();
        drive_b(1'b0, 4'd0, 1'b0, 4'd0);
        drive_a(1'b1, 4'd1, 1'b1, 4'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a} !== {7'd0, 7'd0, 8'd0, 8'd128, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL reset_status: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b, want 0 0 0 128 0 1",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a);
        end
        vecs++;
        if ({enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a, err_a} !== {2'b00, 7'd0, 7'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_ready_next: got rdy=%b%b wn=%0d rn=%0d err=%b, want 00 0 0 0",
                     enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a, err_a);
        end
        do_reset();
    endtask

    task automatic test_fill_reject();
        for (int i = 0; i < 12; i++) begin
            drive_a(1'b1, 4'd10, 1'b0, 4'd0);
            vecs++;
            if ({enq_ready_a, wptr_n_a} !== {1'b1, 7'((i + 1) * 10)}) begin
                errs++;
                $display("FAIL fill_lookahead[%0d]: got rdy=%b wn=%0d, want 1 %0d", i, enq_ready_a, wptr_n_a, (i + 1) * 10);
            end
            tick();
            vecs++;
            if (count_a !== 8'((i + 1) * 10)) begin
                errs++;
                $display("FAIL fill_count[%0d]: got %0d want %0d", i, count_a, (i + 1) * 10);
            end
        end
        drive_a(1'b1, 4'd10, 1'b0, 4'd0);
        vecs++;
        if ({enq_ready_a, wptr_n_a} !== {1'b0, 7'd120}) begin
            errs++;
            $display("FAIL fill_reject_ready: got rdy=%b wn=%0d, want 0 120", enq_ready_a, wptr_n_a);
        end
        if (err_en_lp) exp_err = 1'b1;
        tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a} !== {7'd120, 7'd0, 8'd120, 8'd8, 1'b0, 1'b0, exp_err}) begin
            errs++;
            $display("FAIL fill_reject_state: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b err=%b, want 120 0 120 8 0 0 %b",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a, exp_err);
        end
    endtask

    task automatic test_full_wrap();
        drive_a(1'b1, 4'd8, 1'b0, 4'd0);
        vecs++;
        if ({enq_ready_a, wptr_n_a} !== {1'b1, 7'd0}) begin
            errs++;
            $display("FAIL wrap_lookahead: got rdy=%b wn=%0d, want 1 0", enq_ready_a, wptr_n_a);
        end
        tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a} !== {7'd0, 7'd0, 8'd128, 8'd0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL full_state: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b, want 0 0 128 0 1 0",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a);
        end
        drive_a(1'b1, 4'd10, 1'b1, 4'd10);
        vecs++;
        if ({enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a} !== {2'b01, 7'd0, 7'd10}) begin
            errs++;
            $display("FAIL full_simul_ready: got rdy=%b%b wn=%0d rn=%0d, want 01 0 10",
                     enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a);
        end
        if (err_en_lp) exp_err = 1'b1;
        tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a} !== {7'd0, 7'd10, 8'd118, 8'd10, 1'b0, 1'b0, exp_err}) begin
            errs++;
            $display("FAIL full_simul_state: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b err=%b, want 0 10 118 10 0 0 %b",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin drive_a(1'b1, 4'd10, 1'b0, 4'd0); tick(); end
        drive_a(1'b1, 4'd5, 1'b0, 4'd0); tick();
        for (int i = 0; i < 12; i++) begin drive_a(1'b0, 4'd0, 1'b1, 4'd10); tick(); end
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a} !== {7'd125, 7'd120, 8'd5, 8'd123}) begin
            errs++;
            $display("FAIL b2b_setup: got w=%0d r=%0d c=%0d f=%0d, want 125 120 5 123", wptr_a, rptr_a, count_a, free_a);
        end
        drive_a(1'b1, 4'd7, 1'b1, 4'd5);
        vecs++;
        if ({enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a} !== {2'b11, 7'd4, 7'd125}) begin
            errs++;
            $display("FAIL b2b_lookahead: got rdy=%b%b wn=%0d rn=%0d, want 11 4 125",
                     enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a);
        end
        tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a} !== {7'd4, 7'd125, 8'd7, 8'd121, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL b2b_state: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b, want 4 125 7 121 0 0",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a);
        end
    endtask

    task automatic test_empty();
        drive_a(1'b0, 4'd0, 1'b1, 4'd7); tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, empty_a} !== {7'd4, 7'd4, 8'd0, 8'd128, 1'b1}) begin
            errs++;
            $display("FAIL empty_drain: got w=%0d r=%0d c=%0d f=%0d empty=%b, want 4 4 0 128 1",
                     wptr_a, rptr_a, count_a, free_a, empty_a);
        end
        drive_a(1'b0, 4'd0, 1'b1, 4'd1);
        vecs++;
        if ({deq_ready_a, rptr_n_a} !== {1'b0, 7'd4}) begin
            errs++;
            $display("FAIL empty_deq1_ready: got rdy=%b rn=%0d, want 0 4", deq_ready_a, rptr_n_a);
        end
        if (err_en_lp) exp_err = 1'b1;
        tick();
        vecs++;
        if ({rptr_a, count_a, empty_a, err_a} !== {7'd4, 8'd0, 1'b1, exp_err}) begin
            errs++;
            $display("FAIL empty_deq1_state: got r=%0d c=%0d empty=%b err=%b, want 4 0 1 %b",
                     rptr_a, count_a, empty_a, err_a, exp_err);
        end
        drive_a(1'b0, 4'd0, 1'b1, 4'd0);
        vecs++;
        if ({deq_ready_a, rptr_n_a} !== {1'b1, 7'd4}) begin
            errs++;
            $display("FAIL empty_deq0_ready: got rdy=%b rn=%0d, want 1 4", deq_ready_a, rptr_n_a);
        end
        tick();
        vecs++;
        if ({wptr_a, rptr_a, count_a, empty_a} !== {7'd4, 7'd4, 8'd0, 1'b1}) begin
            errs++;
            $display("FAIL empty_deq0_state: got w=%0d r=%0d c=%0d empty=%b, want 4 4 0 1", wptr_a, rptr_a, count_a, empty_a);
        end
    endtask

    task automatic test_non_pow2();
        do_reset();
        drive_b(1'b1, 4'd10, 1'b0, 4'd0); tick();
        for (int i = 0; i < 8; i++) begin drive_b(1'b1, 4'd10, 1'b1, 4'd10); tick(); end
        drive_b(1'b1, 4'd5, 1'b0, 4'd0); tick();
        vecs++;
        if ({wptr_b, rptr_b, count_b, free_b} !== {7'd95, 7'd80, 7'd15, 7'd85}) begin
            errs++;
            $display("FAIL np2_setup: got w=%0d r=%0d c=%0d f=%0d, want 95 80 15 85", wptr_b, rptr_b, count_b, free_b);
        end
        drive_b(1'b1, 4'd10, 1'b0, 4'd0);
        vecs++;
        if ({enq_ready_b, wptr_n_b} !== {1'b1, 7'd5}) begin
            errs++;
            $display("FAIL np2_lookahead: got rdy=%b wn=%0d, want 1 5", enq_ready_b, wptr_n_b);
        end
        tick();
        vecs++;
        if ({wptr_b, rptr_b, count_b, free_b, full_b, empty_b} !== {7'd5, 7'd80, 7'd25, 7'd75, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL np2_state: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b, want 5 80 25 75 0 0",
                     wptr_b, rptr_b, count_b, free_b, full_b, empty_b);
        end
        drive_b(1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_a(1'b0, 4'd0, 1'b1, 4'd1);
        if (err_en_lp) exp_err = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin drive_a(1'b1, 4'd10, 1'b0, 4'd0); tick(); end
        vecs++;
        if ({wptr_a, count_a, err_a} !== {7'd50, 8'd50, exp_err}) begin
            errs++;
            $display("FAIL areset_setup: got w=%0d c=%0d err=%b, want 50 50 %b", wptr_a, count_a, err_a, exp_err);
        end
        drive_a(1'b1, 4'd10, 1'b1, 4'd3);
        #3 reset_n = 1'b0;
        #1;
        exp_err = 1'b0;
        vecs++;
        if ({wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a} !== {7'd0, 7'd0, 8'd0, 8'd128, 1'b0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL areset_status: got w=%0d r=%0d c=%0d f=%0d full=%b empty=%b err=%b, want 0 0 0 128 0 1 0",
                     wptr_a, rptr_a, count_a, free_a, full_a, empty_a, err_a);
        end
        vecs++;
        if ({enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a} !== {2'b00, 7'd0, 7'd0}) begin
            errs++;
            $display("FAIL areset_ready_next: got rdy=%b%b wn=%0d rn=%0d, want 00 0 0",
                     enq_ready_a, deq_ready_a, wptr_n_a, rptr_n_a);
        end
        do_reset();
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_reject();
        test_full_wrap();
        test_back_to_back();
        test_empty();
        test_non_pow2();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
